rx_frame_fsm: RTL and testbench

Receive-side framing controller for the parallel RCE LDPC codec. Accepts the serial codeword stream produced by the encoder's transmission path (K message bits, then K_N parity bits), packs it into Lm-bit words, and writes them into separate message and parity buffers. When the codeword is complete, it hands the frame to the decoder core through a ready/start handshake.

---
 rtl/rx_frame_fsm_pkg.sv | 23 ++
 rtl/rx_frame_fsm_if.sv | 57 +++++
 rtl/rx_frame_fsm_bit_packer.sv | 43 ++++
 rtl/rx_frame_fsm.sv | 120 ++++++++++++
 tb/tb_rx_frame_fsm.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_frame_fsm_pkg.sv
// rx_frame_fsm shared types and helpers.
// State encodings, buffer selects, clog2.
package rx_frame_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic SEL_MSG = 1'b0;
  localparam logic SEL_PAR = 1'b1;

  // Never returns 0 so widths stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rx_frame_fsm_if.sv
// rx_frame_fsm stream/buffer/decoder bus.
// RX_OVERFLOW_FLAG_EN adds the ovf signal.
interface rx_frame_fsm_if #(
  parameter int ADDR_BITSIZE = 3,
  parameter int Lm           = 32
) ();

  logic                    start;
  logic                    din_valid;
  logic                    din;
  logic                    dec_ready;
  logic                    wr_en;
  logic                    wr_sel;
  logic [ADDR_BITSIZE-1:0] wr_addr;
  logic [Lm-1:0]           wr_data;
  logic                    cw_done;
  logic                    dec_start;
  logic                    busy;
`ifdef RX_OVERFLOW_FLAG_EN
  logic                    ovf;
`endif

  modport master (
    output start,
    output din_valid,
    output din,
    output dec_ready,
    input  wr_en,
    input  wr_sel,
    input  wr_addr,
    input  wr_data,
    input  cw_done,
    input  dec_start,
`ifdef RX_OVERFLOW_FLAG_EN
    input  ovf,
`endif
    input  busy
  );

  modport slave (
    input  start,
    input  din_valid,
    input  din,
    input  dec_ready,
    output wr_en,
    output wr_sel,
    output wr_addr,
    output wr_data,
    output cw_done,
    output dec_start,
`ifdef RX_OVERFLOW_FLAG_EN
    output ovf,
`endif
    output busy
  );

endinterface

// File: rtl/rx_frame_fsm_bit_packer.sv
// Serial-to-parallel packer, first bit in LSB.
// wrap is combinational; word/word_full are registered.
module bit_packer
  import rx_frame_fsm_pkg::*;
#(
  parameter int Lm = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic          din,
  output logic          wrap,
  output logic          word_full,
  output logic [Lm-1:0] word
);

  localparam int CW = clog2(Lm);

  logic [CW-1:0] cnt;
  logic [Lm-1:0] sr;
  logic [Lm-1:0] sr_nxt;

  assign wrap   = accept && (cnt == CW'(Lm - 1));
  assign sr_nxt = {din, sr[Lm-1:1]};

  // Shift in accepted bits; present the word for one cycle on wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      sr        <= '0;
      word_full <= 1'b0;
      word      <= '0;
    end else begin
      word_full <= wrap;
      word      <= wrap ? sr_nxt : '0;
      if (accept) begin
        sr  <= sr_nxt;
        cnt <= wrap ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rx_frame_fsm.sv
// Receive framing FSM: packs message/parity words, hands off to decoder.
// Optional RX_OVERFLOW_FLAG_EN adds a sticky dropped-bit flag (ovf).
module rx_frame_fsm
  import rx_frame_fsm_pkg::*;
#(
  parameter int K            = 32,
  parameter int K_N          = 256,
  parameter int Lm           = 32,
  parameter int ADDR_BITSIZE = clog2(((K > K_N) ? K : K_N) / Lm)
) (
  input logic           clk,
  input logic           rst,
  rx_frame_fsm_if.slave bus
);

  localparam logic [ADDR_BITSIZE-1:0] MSG_LAST =
    ADDR_BITSIZE'(K / Lm - 1);
  localparam logic [ADDR_BITSIZE-1:0] PAR_LAST =
    ADDR_BITSIZE'(K_N / Lm - 1);

  state_t                  state, state_d;
  logic [ADDR_BITSIZE-1:0] wcnt, wcnt_d;
  logic                    accept;
  logic                    wrap;
  logic                    last_word;
  logic                    word_full;
  logic [Lm-1:0]           word;
  logic [ADDR_BITSIZE-1:0] wr_addr_q;
  logic                    wr_sel_q;
  logic                    cw_done_q;
  logic                    dec_start_q;

  assign accept = bus.din_valid &&
                  (state == MSG || state == PAR);

  bit_packer #(.Lm(Lm)) u_pack (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .din       (bus.din),
    .wrap      (wrap),
    .word_full (word_full),
    .word      (word)
  );

  // State and word counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
    end
  end

  // Next state and word counter; counter restarts per buffer.
  always_comb begin
    state_d   = state;
    wcnt_d    = wcnt;
    last_word = (state == PAR) ? (wcnt == PAR_LAST)
                               : (wcnt == MSG_LAST);
    unique case (state)
      IDLE: if (bus.start) state_d = MSG;
      MSG, PAR: begin
        if (wrap) begin
          if (last_word) begin
            state_d = (state == MSG) ? PAR : HOLD;
            wcnt_d  = '0;
          end else begin
            wcnt_d  = wcnt + ADDR_BITSIZE'(1);
          end
        end
      end
      HOLD: if (bus.dec_ready) state_d = IDLE;
    endcase
  end

  // Write sideband and handshake pulses, aligned with word_full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr_q   <= '0;
      wr_sel_q    <= SEL_MSG;
      cw_done_q   <= 1'b0;
      dec_start_q <= 1'b0;
    end else begin
      wr_addr_q   <= wrap ? wcnt : '0;
      wr_sel_q    <= (wrap && state == PAR) ? SEL_PAR : SEL_MSG;
      cw_done_q   <= wrap && state == PAR && last_word;
      dec_start_q <= state == HOLD && bus.dec_ready;
    end
  end

  assign bus.wr_en     = word_full;
  assign bus.wr_data   = word;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_sel    = wr_sel_q;
  assign bus.cw_done   = cw_done_q;
  assign bus.dec_start = dec_start_q;
  assign bus.busy      = state != IDLE;

`ifdef RX_OVERFLOW_FLAG_EN
  logic ovf_q;

  // Sticky flag for bits dropped in IDLE/HOLD; a new start clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      ovf_q <= 1'b0;
    end else if (bus.din_valid &&
                 (state == IDLE || state == HOLD)) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rx_frame_fsm.sv
// Scoreboard bench for rx_frame_fsm (K=64, K_N=128, Lm=32).
// Define RX_OVERFLOW_FLAG_EN to also cover ovf.
module tb_rx_frame_fsm;

  localparam int K   = 64;
  localparam int K_N = 128;
  localparam int LM  = 32;
  localparam int AB  = 3;
  localparam int NB  = K + K_N;
  localparam int NW  = NB / LM;

  typedef struct packed {
    logic          sel;
    logic [AB-1:0] addr;
    logic [LM-1:0] data;
    logic          cw;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  wr_t  sb[$];
  int   wr_cyc[$];
  logic bits[NB];

  rx_frame_fsm_if #(.ADDR_BITSIZE(AB), .Lm(LM)) bus ();

  rx_frame_fsm #(
    .K(K), .K_N(K_N), .Lm(LM), .ADDR_BITSIZE(AB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.wr_en) begin
        wr_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("wr_unexpected", 64'(bus.wr_addr), 64'hFFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_sel", 64'(bus.wr_sel), 64'(e.sel));
          chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
          chk("wr_data", 64'(bus.wr_data), 64'(e.data));
          chk("cw_done", 64'(bus.cw_done), 64'(e.cw));
          chk("busy_wr", 64'(bus.busy), 64'd1);
        end
      end else begin
        chk("cw_orphan", 64'(bus.cw_done), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int w = 0; w < n; w++) begin
      wr_t e;
      logic [LM-1:0] d;
      for (int j = 0; j < LM; j++) d[j] = bits[w*LM + j];
      e.sel  = (w >= K / LM);
      e.addr = AB'((w >= K / LM) ? w - K / LM : w);
      e.data = d;
      e.cw   = (w == NW - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_bits(input int n, input bit gap,
                           input int start_at);
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        bus.din_valid = 1'b0;
        tick();
      end
      bus.din_valid = 1'b1;
      bus.din       = bits[i];
      bus.start     = (i == start_at);
      tick();
    end
    bus.din_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic chk_spacing(input string nm, input int gap);
    for (int i = 1; i < wr_cyc.size(); i++)
      chk(nm, 64'(wr_cyc[i] - wr_cyc[i-1]), 64'(gap));
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_wr_en"}, 64'(bus.wr_en), 64'd0);
    chk({nm, "_wr_sel"}, 64'(bus.wr_sel), 64'd0);
    chk({nm, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({nm, "_wr_data"}, 64'(bus.wr_data), 64'd0);
    chk({nm, "_cw_done"}, 64'(bus.cw_done), 64'd0);
    chk({nm, "_dec_start"}, 64'(bus.dec_start), 64'd0);
    chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lfsr;
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = 1'b0;
    bus.dec_ready = 1'b0;

    lfsr = 16'hACE1;
    for (int i = 0; i < NB; i++) begin
      bits[i] = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5],
              lfsr[15:1]};
    end

    // Reset, then valid without start.
    repeat (3) tick();
    chk_idle_outs("rst");
`ifdef RX_OVERFLOW_FLAG_EN
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.din_valid = 1'b1;
      bus.din       = i[0];
      tick();
    end
    bus.din_valid = 1'b0;
    chk_idle_outs("idle");
`ifdef RX_OVERFLOW_FLAG_EN
    chk("idle_ovf", 64'(bus.ovf), 64'd1);
`endif

    // Frame A: continuous, stray start mid-frame.
    wr_cyc.delete();
    push_words(NW);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("a_busy", 64'(bus.busy), 64'd1);
    send_bits(NB, 1'b0, 5);
    chk("a_cw_done", 64'(bus.cw_done), 64'd1);
    for (int k = 0; k < 10; k++) begin
`ifdef RX_OVERFLOW_FLAG_EN
      bus.din_valid = (k == 3);
      bus.din       = 1'b1;
`endif
      tick();
      chk("hold_dec_start", 64'(bus.dec_start), 64'd0);
      chk("hold_busy", 64'(bus.busy), 64'd1);
    end
    bus.din_valid = 1'b0;
`ifdef RX_OVERFLOW_FLAG_EN
    chk("hold_ovf", 64'(bus.ovf), 64'd1);
`endif
    bus.dec_ready = 1'b1;
    tick();
    bus.dec_ready = 1'b0;
    chk("hs_dec_start", 64'(bus.dec_start), 64'd1);
    chk("hs_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("hs_pulse_end", 64'(bus.dec_start), 64'd0);
    chk("a_drain", 64'(sb.size()), 64'd0);
    chk("a_writes", 64'(wr_cyc.size()), 64'(NW));
    chk_spacing("a_spacing", LM);

    // Frame B: gapped valid, dec_ready already high.
    wr_cyc.delete();
    push_words(NW);
    bus.dec_ready = 1'b1;
    bus.start     = 1'b1;
    bus.din_valid = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.din_valid = 1'b0;
`ifdef RX_OVERFLOW_FLAG_EN
    chk("b_ovf_clr", 64'(bus.ovf), 64'd0);
`endif
    send_bits(NB, 1'b1, -1);
    chk("b_cw_done", 64'(bus.cw_done), 64'd1);
    tick();
    chk("b_dec_start", 64'(bus.dec_start), 64'd1);
    chk("b_busy", 64'(bus.busy), 64'd0);
    bus.dec_ready = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("b_restart", 64'(bus.busy), 64'd1);
    chk("b_drain", 64'(sb.size()), 64'd0);
    chk("b_writes", 64'(wr_cyc.size()), 64'(NW));
    chk_spacing("b_spacing", 2 * LM);

    // Frame C: reset after 40 bits.
    push_words(1);
    send_bits(40, 1'b0, -1);
    bus.din_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk_idle_outs("mrst");
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.din = bits[i];
      tick();
    end
    bus.din_valid = 1'b0;
    chk("c_drain", 64'(sb.size()), 64'd0);
    chk("c_busy", 64'(bus.busy), 64'd0);

    // Frame D: clean restart after reset.
    wr_cyc.delete();
    push_words(NW);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    send_bits(NB, 1'b0, -1);
    bus.dec_ready = 1'b1;
    tick();
    bus.dec_ready = 1'b0;
    chk("d_dec_start", 64'(bus.dec_start), 64'd1);
    tick();
    chk("d_drain", 64'(sb.size()), 64'd0);
    chk("d_writes", 64'(wr_cyc.size()), 64'(NW));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
